ten_bit_serial_subtractor: RTL and testbench
============================================

Name: ten_bit_serial_subtractor

Overview:
Bit-serial 10-bit subtractor, the sequential inverse of the team's ripple-carry 10-bit adder. It is used by the snake position logic to step coordinates backwards: left/up moves and tail retraction. It computes D = A - B one bit per clock with a start/busy/done handshake. An optional modular wrap step brings negative results back into the play-field range.

Parameters:
WIDTH, 10, operand/result width; the datapath and counter scale with it.
WRAP_EN, 1, when 1 a negative result (A < B) is corrected by adding WRAP_LIMIT.
WRAP_LIMIT, 640, modulus added on wrap; must satisfy 0 < WRAP_LIMIT < 2^WIDTH.

Ports:
clk  input  1  system clock; all state changes on rising edge.
resetn  input  1  synchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
A  input  WIDTH  minuend; latched on the accepting edge.
B  input  WIDTH  subtrahend; latched on the accepting edge.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; D and borrow are valid.
D  output  WIDTH  result; held until the next accepted start.
borrow  output  1  1 when A < B (unsigned), independent of wrap; held with D.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on resetn. Reset dominates every other input.
- Reset values: busy=0, done=0, D=0, borrow=0. State=IDLE. Internal shift registers, counter and borrow flop are all 0.
- States: IDLE, SUB, FIX, DONE.
- IDLE:
  - On start=1, latch A into ra and B into rb, clear the borrow flop and counter, then go to SUB.
  - While busy (SUB, FIX, DONE), start is ignored.
- SUB: each edge processes the LSB of ra and rb.
  - diff = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - diff shifts into the result register from the MSB side; ra and rb shift right.
  - Counter runs 0..WIDTH-1.
  - At the last bit, latch the final borrow into borrow.
  - Exit: if WRAP_EN=1 and final br=1, go to FIX; otherwise go to DONE.
- FIX: serial add of result + WRAP_LIMIT over WIDTH edges, using the same shift datapath with a carry flop.
  - Carry-out is discarded (mod 2^WIDTH).
  - Then go to DONE.
- DONE: done=1 for exactly this one cycle; the next edge returns to IDLE.
- D and borrow update only on the edge entering DONE. They are stable from the done cycle until the next done.
- Latency, counting edge 0 as the start-accepting edge:
  - done is visible in the cycle after edge WIDTH (10) without wrap, or after edge 2*WIDTH (20) with wrap.
  - IDLE is reached at edge 11 (or 21), so the earliest next accept is edge 12 (or 22).
  - Throughput with start held high: one result every 12 cycles (22 when wrapping).
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - A=B gives D=0, borrow=0.
  - With WRAP_EN=0, D = two's-complement wrap of A - B.
  - If B - A > WRAP_LIMIT, the corrected D is still (A - B + WRAP_LIMIT) mod 2^WIDTH. Range-keeping in that case is the caller's responsibility.
- Reset mid-operation: the next edge returns to IDLE with all outputs at their reset values. The partial result is lost.
- Changes on A or B after acceptance have no effect.

Test Plan:
1. Reset, then start with A=300, B=100 -> done pulses in the cycle after edge 10; D=200, borrow=0; busy low from edge 11.
2. WRAP_EN=1, WRAP_LIMIT=640; A=5, B=10 -> done after edge 20; D=635, borrow=1.
3. WRAP_EN=0; A=0, B=1023 -> D=1, borrow=1 after edge 10. Then A=B=1023 -> D=0, borrow=0.
4. Start with A=50, B=20; pulse start with A=900, B=1 at edge 4 -> the second request is ignored; D=30, done only once.
5. Start with A=700, B=3; drive resetn=0 at edge 5 -> after the next edge busy=0, done=0, D=0, borrow=0. A new start with A=9, B=4 then gives D=5.
6. Hold start=1 continuously with A=20, B=7 -> done pulses every 12 cycles, each with D=13; busy drops for exactly one cycle (IDLE) between operations.

Source files
------------

// File: rtl/ten_bit_serial_subtractor.sv
// Bit-serial subtractor, one bit per clock, with an optional
// modular wrap step that adds WRAP_LIMIT back to negative results.
module ten_bit_serial_subtractor #(
  parameter int WIDTH      = 10,
  parameter bit WRAP_EN    = 1'b1,
  parameter int WRAP_LIMIT = 640
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             neg;

  logic diff;
  logic br_next;
  logic sum;
  logic cy_next;
  logic last;

  assign diff    = ra[0] ^ rb[0] ^ br;
  assign br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
  // FIX reuses res as the addend shift register and br as the carry
  assign sum     = res[0] ^ rb[0] ^ br;
  assign cy_next = (res[0] & rb[0]) | (br & (res[0] ^ rb[0]));
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ra    <= A;
            rb    <= B;
            res   <= '0;
            br    <= 1'b0;
            neg   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SUB;
          end
        end
        SUB: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          res <= {diff, res[WIDTH-1:1]};
          br  <= br_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt <= '0;
            if (WRAP_EN && br_next) begin
              rb    <= WIDTH'(WRAP_LIMIT);
              br    <= 1'b0;
              neg   <= 1'b1;
              state <= FIX;
            end else begin
              D      <= {diff, res[WIDTH-1:1]};
              borrow <= br_next;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        FIX: begin
          rb  <= rb >> 1;
          res <= {sum, res[WIDTH-1:1]};
          br  <= cy_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt    <= '0;
            D      <= {sum, res[WIDTH-1:1]};
            borrow <= neg;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ten_bit_serial_subtractor.sv
// Directed bench: one wrapping and one non-wrapping
// instance, checked against hand-computed results.
module tb_ten_bit_serial_subtractor;

  logic       clk = 1'b0;
  logic       resetn;

  logic       start0, busy0, done0, br0;
  logic [9:0] a0, b0, d0;
  logic       start1, busy1, done1, br1;
  logic [9:0] a1, b1, d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ten_bit_serial_subtractor #(
    .WIDTH(10), .WRAP_EN(1'b1), .WRAP_LIMIT(640)
  ) dut_wrap (
    .clk(clk), .resetn(resetn), .start(start0),
    .A(a0), .B(b0), .busy(busy0), .done(done0),
    .D(d0), .borrow(br0)
  );

  ten_bit_serial_subtractor #(
    .WIDTH(10), .WRAP_EN(1'b0), .WRAP_LIMIT(640)
  ) dut_nowrap (
    .clk(clk), .resetn(resetn), .start(start1),
    .A(a1), .B(b1), .busy(busy1), .done(done1),
    .D(d1), .borrow(br1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; lat is the edge index where done is seen.
  task automatic do_op(input bit sel, input logic [9:0] a,
                       input logic [9:0] b, output int lat,
                       output logic [9:0] d, output logic br,
                       output logic bsy);
    lat = -1;
    d   = 'x;
    br  = 1'bx;
    bsy = 1'bx;
    if (sel) begin start1 = 1'b1; a1 = a; b1 = b; end
    else begin start0 = 1'b1; a0 = a; b0 = b; end
    step();
    start0 = 1'b0;
    start1 = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (sel ? done1 : done0) begin
        lat = e;
        d   = sel ? d1 : d0;
        br  = sel ? br1 : br0;
        bsy = sel ? busy1 : busy0;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start0 = 1'b0; a0 = '0; b0 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    step();
    step();
    checks++;
    if ({busy0, done0, d0, br0} !== 13'd0) begin
      errors++;
      $display("FAIL reset_wrap: got %b/%b/%0d/%b want 0/0/0/0",
               busy0, done0, d0, br0);
    end
    checks++;
    if ({busy1, done1, d1, br1} !== 13'd0) begin
      errors++;
      $display("FAIL reset_nowrap: got %b/%b/%0d/%b want 0/0/0/0",
               busy1, done1, d1, br1);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat; logic [9:0] d; logic br, bsy;
    do_op(1'b0, 10'd300, 10'd100, lat, d, br, bsy);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 10", lat);
    end
    checks++;
    if (d !== 10'd200 || br !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got D=%0d br=%b want 200/0", d, br);
    end
    checks++;
    if (bsy !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got %b then %b want 1 then 0",
               bsy, busy0);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [9:0] d; logic br, bsy;
    do_op(1'b0, 10'd5, 10'd10, lat, d, br, bsy);
    checks++;
    if (lat !== 20) begin
      errors++;
      $display("FAIL wrap_latency: got %0d want 20", lat);
    end
    checks++;
    if (d !== 10'd635 || br !== 1'b1) begin
      errors++;
      $display("FAIL wrap_result: got D=%0d br=%b want 635/1", d, br);
    end
  endtask

  task automatic test_nowrap();
    int lat; logic [9:0] d; logic br, bsy;
    do_op(1'b1, 10'd0, 10'd1023, lat, d, br, bsy);
    checks++;
    if (lat !== 10 || d !== 10'd1 || br !== 1'b1) begin
      errors++;
      $display("FAIL nowrap_neg: got lat=%0d D=%0d br=%b want 10/1/1",
               lat, d, br);
    end
    do_op(1'b1, 10'd1023, 10'd1023, lat, d, br, bsy);
    checks++;
    if (lat !== 10 || d !== 10'd0 || br !== 1'b0) begin
      errors++;
      $display("FAIL nowrap_equal: got lat=%0d D=%0d br=%b want 10/0/0",
               lat, d, br);
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int first = -1;
    start0 = 1'b1; a0 = 10'd50; b0 = 10'd20;
    step();
    start0 = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 4) begin start0 = 1'b1; a0 = 10'd900; b0 = 10'd1; end
      step();
      if (e == 4) start0 = 1'b0;
      if (done0) begin
        pulses++;
        if (first < 0) first = e;
      end
    end
    checks++;
    if (pulses !== 1 || first !== 10) begin
      errors++;
      $display("FAIL ignore_done: got %0d pulses at %0d want 1 at 10",
               pulses, first);
    end
    checks++;
    if (d0 !== 10'd30 || br0 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: got D=%0d br=%b want 30/0", d0, br0);
    end
  endtask

  task automatic test_mid_reset();
    int lat; logic [9:0] d; logic br, bsy;
    start0 = 1'b1; a0 = 10'd700; b0 = 10'd3;
    step();
    start0 = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    checks++;
    if ({busy0, done0, d0, br0} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b/%b/%0d/%b want 0/0/0/0",
               busy0, done0, d0, br0);
    end
    do_op(1'b0, 10'd9, 10'd4, lat, d, br, bsy);
    checks++;
    if (lat !== 10 || d !== 10'd5 || br !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: got lat=%0d D=%0d br=%b want 10/5/0",
               lat, d, br);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int idle = 0;
    int bad_d = 0;
    int bad_edge = 0;
    start0 = 1'b1; a0 = 10'd20; b0 = 10'd7;
    step();
    for (int e = 1; e <= 35; e++) begin
      step();
      if (done0) begin
        pulses++;
        if (d0 !== 10'd13) bad_d++;
        if (e % 12 != 10) bad_edge++;
      end
      if (!busy0) begin
        idle++;
        if (e % 12 != 11) bad_edge++;
      end
    end
    start0 = 1'b0;
    checks++;
    if (pulses !== 3 || bad_d !== 0) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses %0d bad D want 3/0",
               pulses, bad_d);
    end
    checks++;
    if (idle !== 3 || bad_edge !== 0) begin
      errors++;
      $display("FAIL b2b_timing: got %0d idle %0d misplaced want 3/0",
               idle, bad_edge);
    end
    for (int e = 0; e < 30 && busy0; e++) step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_nowrap();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
